conv2_window_gen: RTL and testbench

- Producer side of the conv2 window interface: turns the raster-order 8-channel binary feature-map stream from pool1 (13x13x8) into 3x3x8 sliding windows.
- Emits one 72-bit window per valid output position (11x11 = 121 per frame) with a valid strobe.
- Output drives the combinational conv2 popcount/threshold stage through `pixel_windows` / `valid_in_buf`.
- No backpressure: the consumer accepts every window in the cycle it is presented.

---
 rtl/conv2_window_gen_if.sv | 34 +++
 rtl/conv2_window_gen.sv | 108 ++++++++++
 tb/tb_conv2_window_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/conv2_window_gen_if.sv
// Window-generator bus: raster pixel stream in, registered 3x3xCH windows out.
// master = window generator side, slave = pixel producer / window consumer side.
interface conv2_window_gen_if #(
   parameter int unsigned CH = 8,
   parameter int unsigned K  = 3
);
   logic                valid_in;
   logic [CH-1:0]       pixel_in;
   logic [K*K*CH-1:0]   pixel_windows;
   logic                valid_out;
   logic [3:0]          out_row;
   logic [3:0]          out_col;
   logic                frame_done;

   modport master (
      input  valid_in,
      input  pixel_in,
      output pixel_windows,
      output valid_out,
      output out_row,
      output out_col,
      output frame_done
   );

   modport slave (
      output valid_in,
      output pixel_in,
      input  pixel_windows,
      input  valid_out,
      input  out_row,
      input  out_col,
      input  frame_done
   );
endinterface

// File: rtl/conv2_window_gen.sv
// Sliding 3x3xCH window generator over a raster-order binary feature map,
// built from two line buffers and a 3x3 column shift window.
module conv2_window_gen #(
   parameter int unsigned IMG_W = 13,
   parameter int unsigned IMG_H = 13,
   parameter int unsigned CH    = 8,
   parameter int unsigned K     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   conv2_window_gen_if.master      bus
);

   localparam int unsigned WIN_W = K * K * CH;

   // r_lb1 holds input row r-1, r_lb2 holds input row r-2
   logic [CH-1:0]    r_lb1 [IMG_W];
   logic [CH-1:0]    r_lb2 [IMG_W];
   logic [CH-1:0]    r_win [K][K];

   logic [3:0]       r_in_row;
   logic [3:0]       r_in_col;
   logic [WIN_W-1:0] r_pixel_windows;
   logic             r_valid_out;
   logic [3:0]       r_out_row;
   logic [3:0]       r_out_col;
   logic             r_frame_done;

   logic [CH-1:0]    w_col [K];
   logic [CH-1:0]    w_win [K][K];
   logic [WIN_W-1:0] w_packed;
   logic             w_col_last;
   logic             w_row_last;
   logic             w_emit;

   assign w_col_last = (r_in_col == 4'(IMG_W - 1));
   assign w_row_last = (r_in_row == 4'(IMG_H - 1));
   assign w_emit     = (r_in_row >= 4'd2) && (r_in_col >= 4'd2);

   // The window is assembled from the incoming column so it is registered
   // in the same edge that accepts pixel (r,c).
   always_comb begin
      w_col[0] = r_lb2[r_in_col];
      w_col[1] = r_lb1[r_in_col];
      w_col[2] = bus.pixel_in;
      for (int unsigned kr = 0; kr < K; kr++) begin
         for (int unsigned kc = 0; kc < K - 1; kc++) begin
            w_win[kr][kc] = r_win[kr][kc + 1];
         end
         w_win[kr][K - 1] = w_col[kr];
      end
      w_packed = '0;
      for (int unsigned ch = 0; ch < CH; ch++) begin
         for (int unsigned kr = 0; kr < K; kr++) begin
            for (int unsigned kc = 0; kc < K; kc++) begin
               w_packed[ch * K * K + kr * K + kc] = w_win[kr][kc][ch];
            end
         end
      end
   end

   // Storage is left uncleared on reset; row/column gating masks stale data.
   always_ff @(posedge clk) begin
      if (bus.valid_in) begin
         r_lb2[r_in_col] <= r_lb1[r_in_col];
         r_lb1[r_in_col] <= bus.pixel_in;
         r_win           <= w_win;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_row        <= '0;
         r_in_col        <= '0;
         r_pixel_windows <= '0;
         r_valid_out     <= 1'b0;
         r_out_row       <= '0;
         r_out_col       <= '0;
         r_frame_done    <= 1'b0;
      end else begin
         r_valid_out     <= 1'b0;
         r_frame_done    <= 1'b0;
         r_pixel_windows <= '0;
         if (bus.valid_in) begin
            if (w_col_last) begin
               r_in_col <= '0;
               r_in_row <= w_row_last ? 4'd0 : r_in_row + 4'd1;
            end else begin
               r_in_col <= r_in_col + 4'd1;
            end
            if (w_emit) begin
               r_valid_out     <= 1'b1;
               r_pixel_windows <= w_packed;
               r_out_row       <= r_in_row - 4'd2;
               r_out_col       <= r_in_col - 4'd2;
               r_frame_done    <= w_row_last && w_col_last;
            end
         end
      end
   end

   assign bus.pixel_windows = r_pixel_windows;
   assign bus.valid_out     = r_valid_out;
   assign bus.out_row       = r_out_row;
   assign bus.out_col       = r_out_col;
   assign bus.frame_done    = r_frame_done;

endmodule

// File: tb/tb_conv2_window_gen.sv
// Directed bench for conv2_window_gen: image-based window model, checked
// cycle by cycle with immediate assertions.
module tb_conv2_window_gen;

   localparam int W  = 13;
   localparam int H  = 13;
   localparam int C  = 8;
   localparam int KK = 3;
   localparam int WB = KK * KK * C;

   logic clk = 1'b0;
   logic rst = 1'b1;

   conv2_window_gen_if #(.CH(C), .K(KK)) bus ();

   conv2_window_gen #(
      .IMG_W (W),
      .IMG_H (H),
      .CH    (C),
      .K     (KK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [C-1:0] img   [H][W];
   logic [C-1:0] img_a [H][W];
   int checks = 0;
   int errors = 0;
   int n_win  = 0;
   int n_done = 0;
   int tr     = 0;
   int tc     = 0;

   task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Window for accepted pixel (r,c): rows r-2..r, cols c-2..c, bit ch*9+kr*3+kc
   function automatic logic [WB-1:0] exp_win(input int r, input int c);
      logic [WB-1:0] w;
      w = '0;
      for (int ch = 0; ch < C; ch++)
         for (int kr = 0; kr < KK; kr++)
            for (int kc = 0; kc < KK; kc++)
               w[ch * 9 + kr * 3 + kc] = img[r - 2 + kr][c - 2 + kc][ch];
      return w;
   endfunction

   task automatic push(input logic [C-1:0] pix);
      bit emit;
      @(negedge clk);
      bus.valid_in = 1'b1;
      bus.pixel_in = pix;
      @(posedge clk);
      #1;
      emit = (tr >= 2) && (tc >= 2);
      check("valid_out", WB'(bus.valid_out), WB'(emit));
      if (emit) begin
         check("out_row", WB'(bus.out_row), WB'(tr - 2));
         check("out_col", WB'(bus.out_col), WB'(tc - 2));
         check("window", bus.pixel_windows, exp_win(tr, tc));
         check("frame_done", WB'(bus.frame_done), WB'((tr == H - 1) && (tc == W - 1)));
      end else begin
         check("window_zero", bus.pixel_windows, '0);
         check("frame_done_zero", WB'(bus.frame_done), '0);
      end
      if (bus.valid_out) n_win++;
      if (bus.frame_done) n_done++;
      if (tc == W - 1) begin
         tc = 0;
         tr = (tr == H - 1) ? 0 : tr + 1;
      end else begin
         tc++;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.pixel_in = C'($urandom);
      @(posedge clk);
      #1;
      check("idle_valid", WB'(bus.valid_out), '0);
      check("idle_window", bus.pixel_windows, '0);
      check("idle_done", WB'(bus.frame_done), '0);
      if (bus.valid_out) n_win++;
      if (bus.frame_done) n_done++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.valid_in = 1'b0;
      @(posedge clk);
      #1;
      check("rst_valid", WB'(bus.valid_out), '0);
      check("rst_window", bus.pixel_windows, '0);
      check("rst_row", WB'(bus.out_row), '0);
      check("rst_col", WB'(bus.out_col), '0);
      check("rst_done", WB'(bus.frame_done), '0);
      rst = 1'b0;
      tr = 0;
      tc = 0;
   endtask

   task automatic feed_frame(input bit gapped);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (gapped) repeat ($urandom_range(0, 2)) idle();
            push(img[r][c]);
         end
   endtask

   task automatic fill_random();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = C'($urandom);
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.pixel_in = '0;

      do_reset();

      // continuous frame
      fill_random();
      img_a = img;
      n_win = 0; n_done = 0;
      feed_frame(1'b0);
      check("cont_count", WB'(n_win), WB'(121));
      check("cont_done", WB'(n_done), WB'(1));

      // single hot pixel (4,5) on channel 2
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = '0;
      img[4][5] = 8'b0000_0100;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            push(img[r][c]);
            if (r == 4 && c == 5) check("pack_bit26", bus.pixel_windows, WB'(1) << 26);
            if (r == 6 && c == 7) check("pack_bit18", bus.pixel_windows, WB'(1) << 18);
         end

      // gapped replay of the continuous frame
      img = img_a;
      n_win = 0; n_done = 0;
      feed_frame(1'b1);
      check("gap_count", WB'(n_win), WB'(121));
      check("gap_done", WB'(n_done), WB'(1));

      // reset after 80 accepted pixels, then a fresh frame
      fill_random();
      for (int i = 0; i < 80; i++) push(img[i / W][i % W]);
      do_reset();
      fill_random();
      n_win = 0; n_done = 0;
      push(img[0][0]);
      for (int i = 1; i < W * 2 + 2; i++) push(img[i / W][i % W]);
      check("rst_first_row", WB'(bus.out_row), WB'(0));
      check("rst_first_col", WB'(bus.out_col), WB'(0));
      for (int i = W * 2 + 2; i < W * H; i++) push(img[i / W][i % W]);
      check("rst_count", WB'(n_win), WB'(121));
      check("rst_frame_done", WB'(n_done), WB'(1));

      // back-to-back frames with distinct data
      n_win = 0; n_done = 0;
      fill_random();
      feed_frame(1'b0);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = ~C'(r * 16 + c);
      feed_frame(1'b0);
      check("b2b_count", WB'(n_win), WB'(242));
      check("b2b_done", WB'(n_done), WB'(2));

      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
